// File: rtl/logic_avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between NUM_REQUESTERS requesters,
// with an in-order pending FIFO that routes responses back. Define LOGIC_AVALON_MM_ARBITER_FIXED_PRIORITY_EN for fixed priority.
module logic_avalon_mm_arbiter #(
   parameter int NUM_REQUESTERS = 2,
   parameter int DATA_BYTES     = 4,
   parameter int ADDRESS_WIDTH  = 1,
   parameter int MAX_PENDING    = 4
) (
   input  logic                                    aclk,
   input  logic                                    areset_n,
   input  logic [NUM_REQUESTERS-1:0]               req_read,
   input  logic [NUM_REQUESTERS-1:0]               req_write,
   input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
   input  logic [NUM_REQUESTERS*8*DATA_BYTES-1:0]  req_writedata,
   input  logic [NUM_REQUESTERS*DATA_BYTES-1:0]    req_byteenable,
   output logic [NUM_REQUESTERS-1:0]               req_waitrequest,
   output logic [NUM_REQUESTERS-1:0]               req_readdatavalid,
   output logic [NUM_REQUESTERS-1:0]               req_writeresponsevalid,
   output logic [8*DATA_BYTES-1:0]                 req_readdata,
   output logic [1:0]                              req_response,
   output logic                                    m_read,
   output logic                                    m_write,
   output logic [ADDRESS_WIDTH-1:0]                m_address,
   output logic [8*DATA_BYTES-1:0]                 m_writedata,
   output logic [DATA_BYTES-1:0]                   m_byteenable,
   input  logic                                    m_waitrequest,
   input  logic                                    m_readdatavalid,
   input  logic                                    m_writeresponsevalid,
   input  logic [8*DATA_BYTES-1:0]                 m_readdata,
   input  logic [1:0]                              m_response
);

   localparam int N       = NUM_REQUESTERS;
   localparam int D       = 8 * DATA_BYTES;
   localparam int GW      = $clog2(N);
   localparam int PW      = $clog2(MAX_PENDING);
   localparam int COUNT_W = PW + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [1:0]         rst_sync;
   logic               rst_n;
   logic [0:0]         state;
   logic [GW-1:0]      grant;
   logic [GW-1:0]      idle_base;
   logic [GW-1:0]      accept_base;
   logic [N-1:0]       request;
   logic               busy;
   logic               can_issue;
   logic               accept;
   logic               push;
   logic               pop;
   logic               not_empty;
   logic [GW-1:0]      head;
   logic [GW-1:0]      fifo_mem [MAX_PENDING];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [COUNT_W-1:0] count;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) rst_sync <= 2'b00;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // First requesting index at or after start, wrapping.
   function automatic logic [GW-1:0] pick(input logic [N-1:0] req, input logic [GW-1:0] start);
      logic [GW-1:0] result;
      logic          found;
      int            idx;
      result = start;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (!found && req[idx]) begin
            result = GW'(idx);
            found  = 1'b1;
         end
      end
      return result;
   endfunction

   assign request   = req_read | req_write;
   assign busy      = (state == BUSY);
   assign can_issue = (count != COUNT_W'(MAX_PENDING));
   assign not_empty = (count != '0);
   assign head      = fifo_mem[rd_ptr];
   assign push      = accept;
   assign pop       = (m_readdatavalid | m_writeresponsevalid) & not_empty;

   // NOTE: every combinational output gets a default before any conditional assignment, so no latch is inferred.
   always_comb begin
      m_read  = 1'b0;
      m_write = 1'b0;
      req_waitrequest = '1;
      if (busy) begin
         m_read  = can_issue & req_read[grant];
         m_write = can_issue & req_write[grant];
         req_waitrequest[grant] = m_waitrequest | ~can_issue;
      end
   end

   assign accept       = (m_read | m_write) & ~m_waitrequest;
   assign m_address    = req_address[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign m_writedata  = req_writedata[int'(grant)*D +: D];
   assign m_byteenable = req_byteenable[int'(grant)*DATA_BYTES +: DATA_BYTES];

   always_comb begin
      req_readdatavalid      = '0;
      req_writeresponsevalid = '0;
      if (not_empty) begin
         req_readdatavalid[head]      = m_readdatavalid;
         req_writeresponsevalid[head] = m_writeresponsevalid;
      end
   end

   assign req_readdata = m_readdata;
   assign req_response = m_response;

`ifdef LOGIC_AVALON_MM_ARBITER_FIXED_PRIORITY_EN
   assign idle_base   = '0;
   assign accept_base = '0;
`else
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] next_ptr;

   assign next_ptr    = (int'(grant) == N - 1) ? '0 : grant + GW'(1);
   assign idle_base   = rr_ptr;
   assign accept_base = next_ptr;

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n)      rr_ptr <= '0;
      else if (accept) rr_ptr <= next_ptr;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|request) begin
                  grant <= pick(request, idle_base);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (accept) begin
                  if (|request) grant <= pick(request, accept_base);
                  else          state <= IDLE;
               end else if (!request[grant]) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + COUNT_W'(1);
         else if (!push && pop) count <= count - COUNT_W'(1);
      end
   end

   // NOTE: the storage array is not reset; only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge aclk) begin
      if (push) fifo_mem[wr_ptr] <= grant;
   end

   response_without_pending: assert property (@(posedge aclk) disable iff (!rst_n)
      !((m_readdatavalid | m_writeresponsevalid) && !not_empty));

endmodule

// File: tb/tb_logic_avalon_mm_arbiter.sv
// Scoreboard bench for logic_avalon_mm_arbiter: a round-robin order model predicts the
// accepted command stream, and a monitor checks commands and routed responses as they appear.
module tb_logic_avalon_mm_arbiter;

   localparam int N    = 2;
   localparam int A    = 1;
   localparam int B    = 4;
   localparam int D    = 32;
   localparam int MAXP = 4;

   localparam int M_RANDOM = 0;
   localparam int M_HOLD   = 1;
   localparam int M_ALWAYS = 2;
   localparam int M_FLOOD  = 3;

   typedef struct packed {
      logic         rw;
      logic [A-1:0] addr;
      logic [D-1:0] data;
      logic [B-1:0] be;
   } cmd_t;

   typedef struct packed {
      logic [7:0] id;
      cmd_t       c;
   } exp_cmd_t;

   typedef struct packed {
      logic [7:0]   id;
      logic         rw;
      logic [D-1:0] data;
      logic [1:0]   resp;
   } rsp_t;

   logic           aclk = 1'b0;
   logic           areset_n;
   logic [N-1:0]   req_read;
   logic [N-1:0]   req_write;
   logic [N*A-1:0] req_address;
   logic [N*D-1:0] req_writedata;
   logic [N*B-1:0] req_byteenable;
   logic [N-1:0]   req_waitrequest;
   logic [N-1:0]   req_readdatavalid;
   logic [N-1:0]   req_writeresponsevalid;
   logic [D-1:0]   req_readdata;
   logic [1:0]     req_response;
   logic           m_read;
   logic           m_write;
   logic [A-1:0]   m_address;
   logic [D-1:0]   m_writedata;
   logic [B-1:0]   m_byteenable;
   logic           m_waitrequest;
   logic           m_readdatavalid;
   logic           m_writeresponsevalid;
   logic [D-1:0]   m_readdata;
   logic [1:0]     m_response;

   logic_avalon_mm_arbiter #(
      .NUM_REQUESTERS(N), .DATA_BYTES(B), .ADDRESS_WIDTH(A), .MAX_PENDING(MAXP)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .req_read(req_read), .req_write(req_write), .req_address(req_address),
      .req_writedata(req_writedata), .req_byteenable(req_byteenable),
      .req_waitrequest(req_waitrequest), .req_readdatavalid(req_readdatavalid),
      .req_writeresponsevalid(req_writeresponsevalid), .req_readdata(req_readdata),
      .req_response(req_response),
      .m_read(m_read), .m_write(m_write), .m_address(m_address),
      .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
      .m_writeresponsevalid(m_writeresponsevalid), .m_readdata(m_readdata),
      .m_response(m_response)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   cmd_t     req_q [N][$];
   exp_cmd_t exp_cmd [$];
   rsp_t     slave_q [$];
   rsp_t     exp_rsp [$];

   bit       cur_valid [N];
   cmd_t     cur [N];
   logic [N-1:0] last_wait;
   bit       wr_rand     = 0;
   bit       force_resp  = 0;
   int       rsp_mode    = M_HOLD;
   int       rsp_credit  = 0;
   int       model_ptr   = 0;
   int       phase_acc   = 0;
   int       first_acc_cyc = 0;
   int       last_acc_cyc  = 0;
   int       last_rsp_cyc  = 0;
   int       start_cyc     = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compares each accepted command and each routed response against the queues.
   always @(negedge aclk) begin : mon
      exp_cmd_t     e;
      rsp_t         r;
      logic [N-1:0] oh;
      logic [N-1:0] erv;
      logic [N-1:0] ewv;
      if ((m_read || m_write) && !m_waitrequest) begin
         if (phase_acc == 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
         phase_acc++;
         if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", 128'(1), 128'(0));
         end else begin
            e = exp_cmd.pop_front();
            check("cmd", 128'({m_write, m_read, m_address, m_writedata, m_byteenable}),
                  128'({e.c.rw, ~e.c.rw, e.c.addr, e.c.data, e.c.be}));
            r.id   = e.id;
            r.rw   = e.c.rw;
            r.data = $urandom;
            r.resp = force_resp ? 2'b10 : 2'($urandom_range(0, 3));
            slave_q.push_back(r);
            exp_rsp.push_back(r);
         end
      end
      if (|req_readdatavalid || |req_writeresponsevalid) begin
         last_rsp_cyc = cyc;
         if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 128'({req_readdatavalid, req_writeresponsevalid}), 128'(0));
         end else begin
            r   = exp_rsp.pop_front();
            oh  = N'(1) << r.id;
            erv = r.rw ? '0 : oh;
            ewv = r.rw ? oh : '0;
            check("rsp", 128'({req_readdatavalid, req_writeresponsevalid, req_response, req_readdata}),
                  128'({erv, ewv, r.resp, r.data}));
         end
      end
   end

   // Downstream slave: returns responses in order according to rsp_mode.
   initial begin : rsp_drv
      bit   go;
      rsp_t r;
      m_readdatavalid      = 1'b0;
      m_writeresponsevalid = 1'b0;
      m_readdata           = '0;
      m_response           = '0;
      forever begin
         @(posedge aclk);
         #2;
         m_readdatavalid      = 1'b0;
         m_writeresponsevalid = 1'b0;
         go = 0;
         case (rsp_mode)
            M_RANDOM: go = (slave_q.size() > 0) && ($urandom_range(0, 1) == 1);
            M_HOLD: if (slave_q.size() > 0 && rsp_credit > 0) begin
               go = 1;
               rsp_credit--;
            end
            M_ALWAYS: go = (slave_q.size() > 0);
            M_FLOOD: begin
               m_readdatavalid = 1'b1;
               m_readdata      = $urandom;
               m_response      = 2'b00;
            end
            default: go = 0;
         endcase
         if (go) begin
            r = slave_q.pop_front();
            m_readdatavalid      = ~r.rw;
            m_writeresponsevalid = r.rw;
            m_readdata           = r.data;
            m_response           = r.resp;
         end
      end
   end

   function automatic cmd_t rand_cmd(input logic rw);
      cmd_t c;
      c.rw   = rw;
      c.addr = A'($urandom_range(0, (1 << A) - 1));
      c.data = $urandom;
      c.be   = B'($urandom_range(1, (1 << B) - 1));
      return c;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (req_q[i].size() != 0) return 0;
      return 1;
   endfunction

   // Expected accept order: repeatedly serve the first non-empty requester at or after the pointer.
   task automatic model_order();
      int       idx [N];
      int       w;
      int       base;
      exp_cmd_t e;
      for (int i = 0; i < N; i++) idx[i] = 0;
      while (1) begin
`ifdef LOGIC_AVALON_MM_ARBITER_FIXED_PRIORITY_EN
         base = 0;
`else
         base = model_ptr;
`endif
         w = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (base + k) % N;
            if (w < 0 && idx[j] < req_q[j].size()) w = j;
         end
         if (w < 0) break;
         e.id = 8'(w);
         e.c  = req_q[w][idx[w]];
         exp_cmd.push_back(e);
         idx[w]++;
         model_ptr = (w + 1) % N;
      end
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         req_read[i]             = cur_valid[i] && !cur[i].rw;
         req_write[i]            = cur_valid[i] && cur[i].rw;
         req_address[i*A +: A]   = cur[i].addr;
         req_writedata[i*D +: D] = cur[i].data;
         req_byteenable[i*B +: B] = cur[i].be;
      end
   endtask

   task automatic step();
      bit acc [N];
      @(negedge aclk);
      last_wait = req_waitrequest;
      for (int i = 0; i < N; i++) acc[i] = cur_valid[i] && !req_waitrequest[i];
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] || !cur_valid[i]) begin
            if (req_q[i].size() > 0) begin
               cur[i]       = req_q[i].pop_front();
               cur_valid[i] = 1;
            end else begin
               cur_valid[i] = 0;
            end
         end
      end
      drive_bus();
      m_waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic start_phase();
      model_order();
      phase_acc = 0;
      step();
      start_cyc = cyc;
   endtask

   task automatic finish_phase();
      int n;
      n = 0;
      while (!(exp_cmd.size() == 0 && queues_empty()) && n < 3000) begin
         step();
         n++;
      end
      check("phase_timeout", 128'(n >= 3000), 128'(0));
      repeat (3) step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((slave_q.size() != 0 || exp_rsp.size() != 0) && n < 3000) begin
         step();
         n++;
      end
      check("drain_timeout", 128'(n >= 3000), 128'(0));
   endtask

   initial begin
      areset_n      = 1'b0;
      m_waitrequest = 1'b0;
      for (int i = 0; i < N; i++) begin
         cur_valid[i] = 0;
         cur[i]       = '0;
      end
      drive_bus();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("reset_waitrequest", 128'(req_waitrequest), 128'({N{1'b1}}));
      check("reset_cmd", 128'({m_read, m_write}), 128'(0));
      check("reset_valid", 128'({req_readdatavalid, req_writeresponsevalid}), 128'(0));
      @(posedge aclk);
      #1 areset_n = 1'b1;
      repeat (4) step();

      // Single requester reads, grant one cycle after request.
      rsp_mode = M_ALWAYS;
      req_q[0].push_back('{rw: 1'b0, addr: 1'b0, data: 32'h1111_0000, be: 4'hf});
      req_q[0].push_back('{rw: 1'b0, addr: 1'b1, data: 32'h2222_0000, be: 4'hf});
      start_phase();
      finish_phase();
      check("grant_latency", 128'(first_acc_cyc - start_cyc), 128'(1));
      drain();

      // Both requesters write continuously.
      for (int i = 0; i < 6; i++) begin
         req_q[0].push_back(rand_cmd(1'b1));
         req_q[1].push_back(rand_cmd(1'b1));
      end
      start_phase();
      finish_phase();
      check("contend_latency", 128'(first_acc_cyc - start_cyc), 128'(1));
`ifndef LOGIC_AVALON_MM_ARBITER_FIXED_PRIORITY_EN
      check("back_to_back", 128'(last_acc_cyc - first_acc_cyc), 128'(11));
`endif
      drain();

      // Pending limit: responses withheld, six reads offered.
      rsp_mode = M_HOLD;
      rsp_credit = 0;
      for (int i = 0; i < 6; i++) req_q[0].push_back(rand_cmd(1'b0));
      start_phase();
      repeat (20) step();
      check("full_accept_count", 128'(phase_acc), 128'(MAXP));
      check("full_waitrequest", 128'(last_wait[0]), 128'(1));
      rsp_credit = 1;
      repeat (3) step();
      check("release_accept_count", 128'(phase_acc), 128'(MAXP + 1));
      check("release_latency", 128'(last_acc_cyc - last_rsp_cyc), 128'(1));
      rsp_mode = M_ALWAYS;
      finish_phase();
      drain();

      // Writes from 0 interleaved with reads from 1, error response code.
      force_resp = 1;
      rsp_mode   = M_RANDOM;
      for (int i = 0; i < 4; i++) begin
         req_q[0].push_back(rand_cmd(1'b1));
         req_q[1].push_back(rand_cmd(1'b0));
      end
      start_phase();
      finish_phase();
      drain();
      force_resp = 0;

      // Randomized traffic with downstream stalls and bursts of withheld responses.
      wr_rand = 1;
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = $urandom_range(0, 5);
            for (int k = 0; k < cnt; k++) req_q[i].push_back(rand_cmd(1'($urandom_range(0, 1))));
         end
         rsp_mode = (p % 3 == 0) ? M_HOLD : (($urandom_range(0, 1) == 1) ? M_ALWAYS : M_RANDOM);
         start_phase();
         if (rsp_mode == M_HOLD) begin
            repeat (8) step();
            rsp_mode = M_RANDOM;
         end
         finish_phase();
         drain();
      end
      wr_rand = 0;

      // Reset with three transactions pending.
      rsp_mode = M_HOLD;
      for (int i = 0; i < 3; i++) req_q[0].push_back(rand_cmd(1'b0));
      start_phase();
      begin
         int n;
         n = 0;
         while (phase_acc < 3 && n < 50) begin
            step();
            n++;
         end
      end
      check("pre_reset_accepts", 128'(phase_acc), 128'(3));
      repeat (2) step();
      rsp_mode = M_FLOOD;
      areset_n = 1'b0;
      @(negedge aclk);
      check("mid_reset_waitrequest", 128'(req_waitrequest), 128'({N{1'b1}}));
      check("mid_reset_cmd", 128'({m_read, m_write}), 128'(0));
      check("mid_reset_valid", 128'({req_readdatavalid, req_writeresponsevalid}), 128'(0));
      @(posedge aclk);
      #1 rsp_mode = M_HOLD;
      @(posedge aclk);
      #1;
      slave_q.delete();
      exp_rsp.delete();
      exp_cmd.delete();
      model_ptr = 0;
      areset_n  = 1'b1;
      repeat (4) step();
      rsp_mode = M_ALWAYS;
      req_q[1].push_back(rand_cmd(1'b0));
      req_q[0].push_back(rand_cmd(1'b0));
      start_phase();
      finish_phase();
      drain();
      check("final_cmd_queue", 128'(exp_cmd.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
